// File: rtl/mul4_seq.sv
// mul4_seq: 4x4 unsigned sequential multiplier built from one 2x2 multiplier
// stepped over four cycles, accumulating shifted partial products.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - synchronous reset, active-high
//   start  - begin a multiply (accepted only when idle)
//   a_in   - 4-bit unsigned multiplicand, captured on accept
//   b_in   - 4-bit unsigned multiplier, captured on accept
//   busy   - high while the four-step sequence runs
//   done   - completion flag (pulse, or held when STICKY_DONE=1)
//   p      - 8-bit product of the last completed multiply
//
// Parameter STICKY_DONE: 0 = one-cycle done pulse, 1 = done held until the
// next accepted start or reset.
// Optional macro MUL4_SEQ_ZERO_SKIP_EN: a zero operand completes at once
// (p=0, done next cycle) without entering RUN.

module mul4_seq #(
    parameter bit STICKY_DONE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic [1:0]  k_q;
    logic [7:0]  acc_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [7:0]  p_q;
    logic        done_q;
    logic        busy_q;

    logic [1:0]  opa_d;
    logic [1:0]  opb_d;
    logic [3:0]  pp_d;
    logic [7:0]  pps_d;
    logic [7:0]  sum_d;

    // k[1] picks the multiplicand half, k[0] the multiplier half, so the
    // order is lo*lo, lo*hi, hi*lo, hi*hi.
    assign opa_d = k_q[1] ? ra_q[3:2] : ra_q[1:0];
    assign opb_d = k_q[0] ? rb_q[3:2] : rb_q[1:0];

    // The single 2x2 multiplier shared by every step.
    assign pp_d = {2'b00, opa_d} * {2'b00, opb_d};

    // Weight of the partial product: 0, 2, 2, 4 bits.
    always_comb begin
        pps_d = {4'b0000, pp_d};
        unique case (k_q)
            2'd0: pps_d = {4'b0000, pp_d};
            2'd1: pps_d = {2'b00, pp_d, 2'b00};
            2'd2: pps_d = {2'b00, pp_d, 2'b00};
            2'd3: pps_d = {pp_d, 4'b0000};
        endcase
    end

    assign sum_d = acc_q + pps_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            acc_q   <= 8'd0;
            ra_q    <= 4'd0;
            rb_q    <= 4'd0;
            p_q     <= 8'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!STICKY_DONE) begin
                        done_q <= 1'b0;
                    end
`ifdef MUL4_SEQ_ZERO_SKIP_EN
                    if (start && (a_in == 4'd0 || b_in == 4'd0)) begin
                        p_q    <= 8'd0;
                        done_q <= 1'b1;
                    end else
`endif
                    if (start) begin
                        ra_q    <= a_in;
                        rb_q    <= b_in;
                        acc_q   <= 8'd0;
                        k_q     <= 2'd0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // start is ignored here; operands stay frozen.
                    acc_q <= sum_d;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        p_q     <= sum_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        k_q     <= 2'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: directed self-checking bench for mul4_seq, running a pulse-done
// instance and a sticky-done instance side by side on shared inputs.

module tb_mul4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] p;
    logic       busy_s;
    logic       done_s;
    logic [7:0] p_s;

    int n_cmp = 0;
    int n_err = 0;

    mul4_seq #(.STICKY_DONE(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    mul4_seq #(.STICKY_DONE(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy_s),
        .done  (done_s),
        .p     (p_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] ep;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [3:0] a, input logic [3:0] b);
`ifdef MUL4_SEQ_ZERO_SKIP_EN
        return (a == 4'd0 || b == 4'd0) ? 0 : 4;
`else
        return 4;
`endif
    endfunction

    // Called at a negedge; counts busy cycles until done is seen.
    task automatic wait_done(output int cnt);
        int guard;
        cnt = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) cnt++;
            guard++;
            @(negedge clk);
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] ep);
        int cnt;
        int eb;
        eb = exp_busy(a, b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        chk("sticky_after_accept", {31'd0, done_s}, (eb == 0) ? 32'd1 : 32'd0);
        wait_done(cnt);
        chk("busy_cycles", cnt, eb);
        chk("p", {24'd0, p}, {24'd0, ep});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("p_sticky", {24'd0, p_s}, {24'd0, ep});
        chk("done_sticky", {31'd0, done_s}, 32'd1);
        @(negedge clk);
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("done_sticky_hold", {31'd0, done_s}, 32'd1);
        chk("p_hold", {24'd0, p}, {24'd0, ep});
    endtask

    vec_t vecs[9];

    initial begin
        int cnt;
        int gap;
        int seen;
        logic [7:0] acc_exp [4];

        vecs[0] = '{4'd3,  4'd5,  8'd15};
        vecs[1] = '{4'd15, 4'd15, 8'd225};
        vecs[2] = '{4'd0,  4'd9,  8'd0};
        vecs[3] = '{4'd6,  4'd7,  8'd42};
        vecs[4] = '{4'd1,  4'd1,  8'd1};
        vecs[5] = '{4'd15, 4'd1,  8'd15};
        vecs[6] = '{4'd9,  4'd0,  8'd0};
        vecs[7] = '{4'd12, 4'd10, 8'd120};
        vecs[8] = '{4'd2,  4'd3,  8'd6};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 4'd0;
        b_in  = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_p", {24'd0, p}, 32'd0);
        chk("rst_done_s", {31'd0, done_s}, 32'd0);

        // First vector starts on the first edge with rst low.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].ep);
        end

        // Accumulator progression for 15*15.
        acc_exp[0] = 8'd9;
        acc_exp[1] = 8'd45;
        acc_exp[2] = 8'd81;
        acc_exp[3] = 8'd225;
        start = 1'b1;
        a_in  = 4'd15;
        b_in  = 4'd15;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("acc_step", {24'd0, dut0.acc_q}, {24'd0, acc_exp[i]});
        end
        chk("acc_p", {24'd0, p}, 32'd225);
        chk("acc_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Start while busy is ignored.
        start = 1'b1;
        a_in  = 4'd6;
        b_in  = 4'd7;
        @(negedge clk);
        start = 1'b0;
        cnt = busy ? 1 : 0;
        @(negedge clk);
        if (busy) cnt++;
        start = 1'b1;
        a_in  = 4'd1;
        b_in  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(gap);
        chk("ign_busy_cycles", cnt + gap, 32'd4);
        chk("ign_p", {24'd0, p}, 32'd42);
        @(negedge clk);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || done) seen++;
            @(negedge clk);
        end
        chk("ign_no_restart", seen, 32'd0);

        // Reset aborts a running multiply.
        start = 1'b1;
        a_in  = 4'd10;
        b_in  = 4'd12;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_p", {24'd0, p}, 32'd0);
        chk("abort_done_s", {31'd0, done_s}, 32'd0);
        chk("abort_p_s", {24'd0, p_s}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || done_s || busy) seen++;
            @(negedge clk);
        end
        chk("abort_quiet", seen, 32'd0);
        run_mul(4'd2, 4'd3, 8'd6);

        // Back-to-back: second start in the done cycle.
        start = 1'b1;
        a_in  = 4'd4;
        b_in  = 4'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done(cnt);
        chk("b2b_busy1", cnt, 32'd4);
        chk("b2b_p1", {24'd0, p}, 32'd16);
        chk("b2b_done_s1", {31'd0, done_s}, 32'd1);
        start = 1'b1;
        a_in  = 4'd5;
        b_in  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
        chk("b2b_accept_done", {31'd0, done}, 32'd0);
        chk("b2b_done_s_clr", {31'd0, done_s}, 32'd0);
        gap = 1;
        seen = 0;
        while (!done && gap < 20) begin
            if (p !== 8'd16) seen++;
            gap++;
            @(negedge clk);
        end
        chk("b2b_p_held", seen, 32'd0);
        chk("b2b_gap", gap, 32'd5);
        chk("b2b_p2", {24'd0, p}, 32'd25);
        chk("b2b_done_s2", {31'd0, done_s}, 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
